// File: rtl/ir_nec_transmitter.sv
// NEC infrared frame transmitter: sends {addr, ~addr, cmd, ~cmd} LSB first with a 38 kHz carrier.
// Latency: envelope and busy rise the cycle after accept; a frame is always 121 units long.
// Backpressure: tx_ready is high only in IDLE, so tx_valid is ignored for the whole frame.
module ir_nec_transmitter #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int CNT_W        = 24
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        busy,
    output logic        tx_done,
    output logic        ir_envelope,
    output logic        ir_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK
    } state_t;

    localparam logic [CNT_W-1:0] LEAD_MARK_LD  = CNT_W'(16 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LEAD_SPACE_LD = CNT_W'(8 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNIT_LD       = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LD       = CNT_W'(3 * UNIT_CYCLES - 1);

    localparam int               PH_W  = $clog2(CARRIER_HALF + 1);
    localparam logic [PH_W-1:0]  PH_LD = PH_W'(CARRIER_HALF - 1);

    state_t            state;
    state_t            nxt_state;
    logic              adv;
    logic [CNT_W-1:0]  dur_cnt;
    logic [CNT_W-1:0]  load_val;
    logic [PH_W-1:0]   phase_cnt;
    logic [31:0]       shreg;
    logic [5:0]        bit_cnt;
    logic              dur_end;
    logic              last_bit;
    logic              accept;

    function automatic logic is_mark(input state_t s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
    endfunction

    assign dur_end  = (dur_cnt == '0);
    assign last_bit = (bit_cnt == 6'd31);
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        nxt_state = state;
        adv       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_state = S_LEAD_MARK;
                    adv       = 1'b1;
                end
            end
            S_LEAD_MARK: begin
                if (dur_end) begin
                    nxt_state = S_LEAD_SPACE;
                    adv       = 1'b1;
                end
            end
            S_LEAD_SPACE: begin
                if (dur_end) begin
                    nxt_state = S_BIT_MARK;
                    adv       = 1'b1;
                end
            end
            S_BIT_MARK: begin
                if (dur_end) begin
                    nxt_state = S_BIT_SPACE;
                    adv       = 1'b1;
                end
            end
            S_BIT_SPACE: begin
                if (dur_end) begin
                    nxt_state = last_bit ? S_STOP_MARK : S_BIT_MARK;
                    adv       = 1'b1;
                end
            end
            S_STOP_MARK: begin
                if (dur_end) begin
                    nxt_state = S_IDLE;
                    adv       = 1'b1;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                adv       = 1'b1;
            end
        endcase
    end

    // Space length is decided by the bit currently at the bottom of the shift register.
    always_comb begin
        load_val = '0;
        case (nxt_state)
            S_LEAD_MARK:  load_val = LEAD_MARK_LD;
            S_LEAD_SPACE: load_val = LEAD_SPACE_LD;
            S_BIT_MARK:   load_val = UNIT_LD;
            S_BIT_SPACE:  load_val = shreg[0] ? LONG_LD : UNIT_LD;
            S_STOP_MARK:  load_val = UNIT_LD;
            default:      load_val = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            dur_cnt     <= '0;
            phase_cnt   <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            ir_envelope <= 1'b0;
            ir_out      <= 1'b0;
        end else begin
            state       <= nxt_state;
            tx_ready    <= (nxt_state == S_IDLE);
            busy        <= (nxt_state != S_IDLE);
            tx_done     <= (state == S_STOP_MARK) && adv;
            ir_envelope <= is_mark(nxt_state);

            if (adv) begin
                dur_cnt <= load_val;
            end else if (!dur_end) begin
                dur_cnt <= dur_cnt - CNT_W'(1);
            end

            if (state == S_IDLE && adv) begin
                shreg   <= {~tx_data[7:0], tx_data[7:0], ~tx_data[15:8], tx_data[15:8]};
                bit_cnt <= '0;
            end else if (state == S_BIT_SPACE && adv) begin
                shreg <= shreg >> 1;
                if (bit_cnt != 6'd32) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end

            // Carrier phase restarts high at every mark and is forced low outside marks.
            if (adv && is_mark(nxt_state)) begin
                ir_out    <= 1'b1;
                phase_cnt <= PH_LD;
            end else if (is_mark(nxt_state)) begin
                if (phase_cnt == '0) begin
                    ir_out    <= ~ir_out;
                    phase_cnt <= PH_LD;
                end else begin
                    phase_cnt <= phase_cnt - PH_W'(1);
                end
            end else begin
                ir_out    <= 1'b0;
                phase_cnt <= '0;
            end
        end
    end

    a_out_in_mark: assert property (@(posedge CLOCK_50) disable iff (!resetn) ir_out |-> ir_envelope);
    a_busy_ready:  assert property (@(posedge CLOCK_50) disable iff (!resetn) busy != tx_ready);

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Bench for ir_nec_transmitter: expected per-cycle waveform built from NEC segment lengths.
module tb_ir_nec_transmitter;

    localparam int U     = 8;
    localparam int CH    = 2;
    localparam int FRAME = 121 * U;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic [15:0] tx_data  = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        busy;
    logic        tx_done;
    logic        ir_envelope;
    logic        ir_out;

    ir_nec_transmitter #(
        .UNIT_CYCLES  (U),
        .CARRIER_HALF (CH),
        .CNT_W        (24)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .ir_envelope (ir_envelope),
        .ir_out      (ir_out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int   checks      = 0;
    int   errors      = 0;
    int   fail_prints = 0;
    int   model_acc   = 0;
    int   dut_done    = 0;
    int   busy_len    = 0;
    bit   env_q[$];
    bit   out_q[$];
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;
    logic exp_env  = 1'b0;
    logic exp_out  = 1'b0;
    logic old_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_seg(input bit lvl, input int n);
        for (int j = 0; j < n; j++) begin
            env_q.push_back(lvl);
            out_q.push_back(lvl && (((j / CH) % 2) == 0));
        end
    endtask

    task automatic build_frame(input logic [15:0] d);
        logic [31:0] w;
        w = {~d[7:0], d[7:0], ~d[15:8], d[15:8]};
        push_seg(1'b1, 16 * U);
        push_seg(1'b0, 8 * U);
        for (int i = 0; i < 32; i++) begin
            push_seg(1'b1, U);
            push_seg(1'b0, w[i] ? 3 * U : U);
        end
        push_seg(1'b1, U);
    endtask

    // Reference model: one queue entry per cycle of the frame.
    initial forever begin
        @(posedge CLOCK_50 or negedge resetn);
        if (!resetn) begin
            env_q.delete();
            out_q.delete();
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_env  = 1'b0;
            exp_out  = 1'b0;
        end else begin
            old_busy = exp_busy;
            if (!old_busy && tx_valid) begin
                build_frame(tx_data);
                model_acc++;
            end
            if (env_q.size() > 0) begin
                exp_env  = env_q.pop_front();
                exp_out  = out_q.pop_front();
                exp_busy = 1'b1;
                exp_done = 1'b0;
            end else begin
                exp_env  = 1'b0;
                exp_out  = 1'b0;
                exp_busy = 1'b0;
                exp_done = old_busy;
            end
        end
    end

    // Per-cycle compare, sampled on the falling edge.
    initial forever begin
        logic [4:0] got;
        logic [4:0] expv;
        @(negedge CLOCK_50);
        if (resetn) begin
            got  = {tx_ready, busy, tx_done, ir_envelope, ir_out};
            expv = {~exp_busy, exp_busy, exp_done, exp_env, exp_out};
            checks++;
            if (got !== expv) begin
                errors++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("FAIL cycle_check t=%0t ready/busy/done/env/out got %b expected %b", $time, got, expv);
                end
            end
            checks++;
            if (ir_out && !ir_envelope) begin
                errors++;
                $display("FAIL carrier_outside_mark t=%0t ir_out=%b ir_envelope=%b", $time, ir_out, ir_envelope);
            end
            checks++;
            if (busy === tx_ready) begin
                errors++;
                $display("FAIL busy_vs_ready t=%0t busy=%b tx_ready=%b", $time, busy, tx_ready);
            end
            if (tx_done === 1'b1) dut_done++;
            if (busy === 1'b1) begin
                busy_len++;
            end else if (busy_len != 0) begin
                checks++;
                if (busy_len != FRAME) begin
                    errors++;
                    $display("FAIL busy_length got %0d cycles expected %0d", busy_len, FRAME);
                end
                busy_len = 0;
            end
        end else begin
            busy_len = 0;
        end
    end

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        @(negedge CLOCK_50);
        #1;
        while (exp_busy && n < 3000) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        check("send_wait_ready", {31'd0, exp_busy}, 0);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLOCK_50);
        #1;
        while (exp_busy && n < 3000) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        check("wait_idle_timeout", {31'd0, exp_busy}, 0);
        @(negedge CLOCK_50);
        #1;
    endtask

    // Decode the DUT envelope like a receiver would; also checks the 1,1,0,0 carrier in every mark.
    task automatic capture_decode(output logic [31:0] val, output int bad);
        logic env_cap[FRAME];
        logic out_cap[FRAME];
        int   runs[$];
        int   len;
        int   j;
        logic lvl;
        bad = 0;
        val = '0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLOCK_50);
            env_cap[i] = ir_envelope;
            out_cap[i] = ir_out;
        end
        lvl = env_cap[0];
        if (!lvl) bad++;
        len = 0;
        j   = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (env_cap[i] == lvl) begin
                len++;
            end else begin
                runs.push_back(len);
                lvl = env_cap[i];
                len = 1;
            end
            if (env_cap[i]) begin
                if (out_cap[i] != (((j / 2) % 2) == 0)) bad++;
                j++;
            end else begin
                if (out_cap[i]) bad++;
                j = 0;
            end
        end
        runs.push_back(len);
        if (runs.size() != 67) begin
            bad++;
        end else begin
            if (runs[0] != 128) bad++;
            if (runs[1] != 64) bad++;
            if (runs[66] != 8) bad++;
            for (int i = 0; i < 32; i++) begin
                if (runs[2 + 2 * i] != U) bad++;
                if (runs[3 + 2 * i] != U && runs[3 + 2 * i] != 3 * U) bad++;
                val[i] = (runs[3 + 2 * i] == 3 * U);
            end
        end
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] val;
        int          bad;
        int          d0;
        int          acc0;
        int          n;
        int          falls;
        logic        prev;

        repeat (3) @(negedge CLOCK_50);
        check("reset_outputs", {27'd0, tx_ready, busy, tx_done, ir_envelope, ir_out}, 32'h10);
        #1 resetn = 1'b1;

        // Idle after reset
        repeat (50) @(negedge CLOCK_50);
        #1;
        check("idle_outputs", {27'd0, tx_ready, busy, tx_done, ir_envelope, ir_out}, 32'h10);

        // 16'h00FF
        d0 = dut_done;
        send(16'h00FF);
        check("model_frame_len", env_q.size() + 1, 968);
        capture_decode(val, bad);
        check("decode_00FF", val, 32'h00FFFF00);
        check("shape_00FF", bad, 0);
        wait_idle();
        check("done_once_00FF", dut_done - d0, 1);

        // 16'hA53C
        d0 = dut_done;
        send(16'hA53C);
        capture_decode(val, bad);
        check("decode_A53C", val, 32'hC33C5AA5);
        check("shape_A53C", bad, 0);
        wait_idle();
        check("done_once_A53C", dut_done - d0, 1);

        // tx_valid while busy is ignored
        d0 = dut_done;
        send(16'h5AC3);
        repeat (198) @(negedge CLOCK_50);
        #1;
        tx_data  = 16'h1234;
        tx_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        tx_valid = 1'b0;
        wait_idle();
        check("ignored_valid_done", dut_done - d0, 1);

        // tx_valid held through tx_done: back-to-back frame
        d0 = dut_done;
        send(16'h0F0F);
        tx_data  = 16'h7E81;
        tx_valid = 1'b1;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (tx_done !== 1'b1 && n < 2000);
        check("held_done_seen", {31'd0, tx_done}, 1);
        @(negedge CLOCK_50);
        check("zero_gap_busy", {30'd0, busy, ir_envelope}, 32'h3);
        #1 tx_valid = 1'b0;
        wait_idle();
        check("back_to_back_done", dut_done - d0, 2);

        // Reset during the 10th bit space
        d0    = dut_done;
        send(16'hA53C);
        n     = 0;
        falls = 0;
        prev  = 1'b0;
        while (falls < 11 && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
            if (prev && !ir_envelope) falls++;
            prev = ir_envelope;
        end
        check("tenth_space_reached", falls, 11);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_outputs", {27'd0, tx_ready, busy, tx_done, ir_envelope, ir_out}, 32'h10);
        repeat (3) @(negedge CLOCK_50);
        #1 resetn = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        #1;
        check("no_done_after_abort", dut_done - d0, 0);
        check("ready_after_abort", {31'd0, tx_ready}, 1);
        d0 = dut_done;
        send(16'h81F0);
        capture_decode(val, bad);
        check("decode_after_reset", val, 32'h0FF07E81);
        check("shape_after_reset", bad, 0);
        wait_idle();
        check("done_after_reset", dut_done - d0, 1);

        // Randomized frames with random ignored requests
        acc0 = model_acc;
        d0   = dut_done;
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 15)) @(negedge CLOCK_50);
            send(16'($urandom));
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                repeat ($urandom_range(50, 250)) @(negedge CLOCK_50);
                #1;
                tx_data  = 16'($urandom);
                tx_valid = 1'b1;
                @(posedge CLOCK_50);
                #1;
                tx_valid = 1'b0;
            end
            wait_idle();
        end
        check("random_accepts", model_acc - acc0, 6);
        check("random_done_eq_accept", dut_done - d0, model_acc - acc0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_nec_transmitter.md
Name: ir_nec_transmitter

Overview:
- Transmits one 16-bit code as a single NEC-format infrared frame. It is the send-side counterpart of the 16-bit IR reading path that drives the VGA game controller.
- Latches {address, command} via a valid/ready handshake. Drives a 38 kHz modulated LED output plus an unmodulated envelope for debug and loopback.
- Sits beside the IR receiver. A frame sent from this block reproduces the same 16-bit value on the receiver's ir_in bus.

Parameters:
- UNIT_CYCLES, 28125, clock cycles per NEC unit (562.5 us at 50 MHz); simulation uses 8.
- CARRIER_HALF, 658, clock cycles per carrier half-period (about 38 kHz at 50 MHz); simulation uses 2.
- CNT_W, 24, width of the duration counter; 16*UNIT_CYCLES must be less than 2^CNT_W.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- tx_data  input  16  [15:8] address, [7:0] command.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high only in IDLE; the handshake completes on an edge where tx_valid and tx_ready are both high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse when a frame completes.
- ir_envelope  output  1  high during marks, low during spaces and idle.
- ir_out  output  1  ir_envelope AND carrier, registered.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - ir_out=0, ir_envelope=0, tx_done=0, busy=0, tx_ready=1.
  - Counters and shift register clear.
  - Reset mid-frame aborts the frame silently: no tx_done, output low at once.
- Accept: on the edge where tx_valid & tx_ready, the block latches the 32-bit shift register {~cmd, cmd, ~addr, addr}. Transmission is LSB first, so addr[0] goes out first.
- tx_valid while busy is ignored. tx_data is sampled only at accept.
- State machine: IDLE -> LEAD_MARK -> LEAD_SPACE -> BIT_MARK <-> BIT_SPACE (32 bits) -> STOP_MARK -> IDLE.
- State durations, where U = UNIT_CYCLES:
  - LEAD_MARK: 16U cycles.
  - LEAD_SPACE: 8U cycles.
  - BIT_MARK: U cycles.
  - BIT_SPACE: U cycles for a 0 bit, 3U cycles for a 1 bit.
  - STOP_MARK: U cycles.
- Duration counter:
  - Loads at each state entry and counts down.
  - The state advances on the cycle after the counter reaches its terminal value.
  - Every state lasts exactly its nominal number of cycles.
- Shift register and bit count:
  - The shift register shifts right at the end of each BIT_SPACE.
  - A 6-bit counter tracks bits sent; after the 32nd BIT_SPACE the block enters STOP_MARK.
- Frame length:
  - Each byte/inverse pair contains exactly 8 ones, so every frame has 16 ones.
  - Total frame length is therefore always 121U cycles of busy, independent of data.
- Latency:
  - Accept at edge k: ir_envelope and busy go high from cycle k+1.
  - ir_envelope is high for 16U cycles, then low for 8U, and so on.
  - The cycle after STOP_MARK ends, state is IDLE, tx_done=1 for that one cycle, tx_ready=1, ir_envelope=0.
  - A new accept is legal on that same edge, so back-to-back frames have zero gap.
- Carrier:
  - The phase counter restarts at the first cycle of every mark. ir_out is high for the first CARRIER_HALF cycles of each mark, then toggles every CARRIER_HALF cycles.
  - A mark ending mid-phase truncates the pulse; ir_out drops the same cycle ir_envelope drops.
  - ir_out is never high while ir_envelope is low.
- Arithmetic: all counters are unsigned and never wrap during a legal frame. The bit counter saturates logic at 32.

Test Plan (UNIT_CYCLES=8, CARRIER_HALF=2):
1. Reset then idle 50 cycles -> tx_ready=1; busy, tx_done, ir_out, ir_envelope all 0.
2. Send 16'h00FF -> envelope high 128, low 64, then 32 bit cells (addr 0x00 gives 0-cells of 8/8, ~addr 0xFF gives 1-cells of 8/24, cmd 0xFF gives 1-cells, ~cmd 0x00 gives 0-cells), stop 8 high. busy spans exactly 968 cycles; tx_done pulses once.
3. Send 16'hA53C -> decoding bench sampling the envelope recovers bytes 0xA5, 0x5A, 0x3C, 0xC3 LSB-first. Frame length is again 968 cycles. During every mark, ir_out follows the pattern 1,1,0,0 repeating.
4. Pulse tx_valid with 16'h1234 at cycle 200 of an active frame -> ignored, current frame unchanged, only one tx_done. Holding tx_valid high through tx_done -> second frame starts the next cycle with zero gap.
5. Assert resetn=0 during the 10th BIT_SPACE -> ir_out and ir_envelope are 0 immediately (before the next edge). No tx_done. After release, tx_ready=1 and a fresh frame transmits correctly.
6. Property check over random data -> ir_out implies ir_envelope; tx_done count equals accept count; busy equals NOT tx_ready in every cycle.
